flow_ctrl_fsm: RTL and testbench

Parametrised flow-control state machine that supervises NCH FIFO channels, captures programmable MF/VC/D threshold values during initialisation, and reports INIT/IDLE/ACTIVE/ERROR status to the transmit path. It sits between the configuration interface and the per-channel FIFO bank. It adds per-channel illegal-condition detection, sticky error flags, an error-entry counter and an explicit error-clear handshake.

---
 rtl/flow_ctrl_fsm.sv | 247 ++++++++++++++++++++++++
 tb/tb_flow_ctrl_fsm.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flow_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : flow_ctrl_fsm
//  Description : Flow-control supervisor for a bank of NCH FIFO channels.
//                It captures the MF/VC/D thresholds during initialisation and
//                reports INIT/IDLE/ACTIVE/ERROR status to the transmit path.
//                It also detects illegal per-channel FIFO conditions, keeps
//                sticky per-channel error flags and a saturating count of
//                ERROR entries, and leaves ERROR only through an explicit
//                error-clear handshake.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NCH  number of supervised FIFO channels (1..16)
//    UW   width of each threshold value
//    ECW  width of the error-entry counter
//  Ports
//    clk                      clock, all logic on the rising edge
//    reset                    synchronous reset, active low
//    init_req                 configuration request; holds INIT, loads thresholds
//    umbral_{mf,vc,d}_in      threshold values to capture
//    fifo_full/empty/write/read  per-channel FIFO status and strobes
//    err_clr                  error acknowledge
//    umbral_{mf,vc,d}         captured thresholds (registered)
//    init_out/idle_out/active_out/error_out  one-hot state decode
//    state                    current state code
//    active_chan              non-empty, legal channels while ACTIVE
//    err_chan                 sticky per-channel error flags (registered)
//    err_count                saturating number of ERROR entries (registered)
// ============================================================================
module flow_ctrl_fsm #(
    parameter int NCH = 4,
    parameter int UW  = 4,
    parameter int ECW = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           init_req,
    input  logic [UW-1:0]  umbral_mf_in,
    input  logic [UW-1:0]  umbral_vc_in,
    input  logic [UW-1:0]  umbral_d_in,
    input  logic [NCH-1:0] fifo_full,
    input  logic [NCH-1:0] fifo_empty,
    input  logic [NCH-1:0] fifo_write,
    input  logic [NCH-1:0] fifo_read,
    input  logic           err_clr,
    output logic [UW-1:0]  umbral_mf,
    output logic [UW-1:0]  umbral_vc,
    output logic [UW-1:0]  umbral_d,
    output logic           init_out,
    output logic           idle_out,
    output logic           active_out,
    output logic           error_out,
    output logic [2:0]     state,
    output logic [NCH-1:0] active_chan,
    output logic [NCH-1:0] err_chan,
    output logic [ECW-1:0] err_count
);

    // ------------------------------------------------------------------
    // State encoding. Codes 5..7 are unreachable in normal operation and
    // are steered back to ST_RESET by the default branch below.
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    localparam logic [ECW-1:0] C_CNT_MAX = '1;
    localparam logic [ECW-1:0] C_CNT_ONE = ECW'(1);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [UW-1:0]    r_umbral_mf;
    logic [UW-1:0]    r_umbral_vc;
    logic [UW-1:0]    r_umbral_d;
    logic [NCH-1:0]   r_err_chan;
    logic [ECW-1:0]   r_err_count;

    logic [NCH-1:0]   w_ill;
    logic             w_any_ill;
    logic             w_monitored;
    logic [NCH-1:0]   w_ill_mon;
    logic             w_all_empty;
    logic             w_thr_nonzero;
    logic             w_load;
    logic             w_err_accept;
    logic             w_err_entry;

    // ------------------------------------------------------------------
    // Per-channel illegal-condition detection:
    //   full and empty at once, write into a full FIFO that is not read
    //   in the same cycle (overflow), read from an empty FIFO (underflow).
    // ------------------------------------------------------------------
    generate
        for (genvar c = 0; c < NCH; c++) begin : g_chan
            assign w_ill[c] = (fifo_full[c]  & fifo_empty[c])
                            | (fifo_full[c]  & fifo_write[c] & ~fifo_read[c])
                            | (fifo_empty[c] & fifo_read[c]);
        end
    endgenerate

    assign w_any_ill   = |w_ill;
    assign w_all_empty = &fifo_empty;

    // Illegal conditions only matter once the FIFO bank is in service.
    assign w_monitored = (r_state == ST_IDLE)
                       | (r_state == ST_ACTIVE)
                       | (r_state == ST_ERROR);
    assign w_ill_mon   = w_monitored ? w_ill : '0;

    // INIT exit looks at the captured values, not the live inputs.
    assign w_thr_nonzero = (|r_umbral_mf) | (|r_umbral_vc) | (|r_umbral_d);

    assign w_load       = (r_state == ST_INIT) & init_req;

    // A clear is only honoured once every illegal condition has gone away;
    // a simultaneous illegal condition wins and the FSM stays in ERROR.
    assign w_err_accept = (r_state == ST_ERROR) & err_clr & ~w_any_ill;

    assign w_err_entry  = (w_state_nxt == ST_ERROR) & (r_state != ST_ERROR);

    // ------------------------------------------------------------------
    // Next-state and decode logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        init_out    = 1'b0;
        idle_out    = 1'b0;
        active_out  = 1'b0;
        error_out   = 1'b0;
        active_chan = '0;

        case (r_state)
            ST_RESET: begin
                w_state_nxt = ST_INIT;
            end

            ST_INIT: begin
                init_out = 1'b1;
                // All-zero thresholds keep the block waiting for a valid
                // configuration instead of falling back to RESET.
                if (!init_req && w_thr_nonzero) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_IDLE: begin
                idle_out = 1'b1;
                if (w_any_ill) begin
                    w_state_nxt = ST_ERROR;
                end else if (init_req) begin
                    w_state_nxt = ST_INIT;
                end else if (!w_all_empty) begin
                    w_state_nxt = ST_ACTIVE;
                end
            end

            ST_ACTIVE: begin
                active_out  = 1'b1;
                active_chan = ~fifo_empty & ~w_ill;
                // Reconfiguration requests are not honoured mid-transfer.
                if (w_any_ill) begin
                    w_state_nxt = ST_ERROR;
                end else if (w_all_empty) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_ERROR: begin
                error_out = 1'b1;
                if (w_err_accept) begin
                    w_state_nxt = ST_INIT;
                end
            end

            default: begin
                w_state_nxt = ST_RESET;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Threshold capture. Values are held across ERROR and re-entry to
    // INIT until init_req reloads them.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_umbral_mf <= '0;
            r_umbral_vc <= '0;
            r_umbral_d  <= '0;
        end else if (w_load) begin
            r_umbral_mf <= umbral_mf_in;
            r_umbral_vc <= umbral_vc_in;
            r_umbral_d  <= umbral_d_in;
        end
    end

    // ------------------------------------------------------------------
    // Sticky per-channel error flags. An accepted clear implies no
    // channel is illegal on that edge, so clear and set never collide.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_err_chan <= '0;
        end else if (w_err_accept) begin
            r_err_chan <= '0;
        end else begin
            r_err_chan <= r_err_chan | w_ill_mon;
        end
    end

    // ------------------------------------------------------------------
    // Saturating count of transitions into ERROR
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_err_count <= '0;
        end else if (w_err_entry && (r_err_count != C_CNT_MAX)) begin
            r_err_count <= r_err_count + C_CNT_ONE;
        end
    end

    assign state     = r_state;
    assign umbral_mf = r_umbral_mf;
    assign umbral_vc = r_umbral_vc;
    assign umbral_d  = r_umbral_d;
    assign err_chan  = r_err_chan;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_flow_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flow_ctrl_fsm
//  Description : Self-checking bench for flow_ctrl_fsm. Two instances share
//                all inputs: the default configuration and one with a 2-bit
//                error counter to exercise saturation. Expected values come
//                from directed constants and from a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flow_ctrl_fsm;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       init_req;
    logic       err_clr;
    logic [3:0] umbral_mf_in, umbral_vc_in, umbral_d_in;
    logic [3:0] fifo_full, fifo_empty, fifo_write, fifo_read;

    logic [3:0] umbral_mf, umbral_vc, umbral_d;
    logic       init_out, idle_out, active_out, error_out;
    logic [2:0] state;
    logic [3:0] active_chan, err_chan;
    logic [7:0] err_count;

    logic [3:0] umbral_mf_s, umbral_vc_s, umbral_d_s;
    logic       init_out_s, idle_out_s, active_out_s, error_out_s;
    logic [2:0] state_s;
    logic [3:0] active_chan_s, err_chan_s;
    logic [1:0] err_count_s;

    flow_ctrl_fsm #(.NCH(4), .UW(4), .ECW(8)) dut (
        .clk(clk), .reset(reset), .init_req(init_req),
        .umbral_mf_in(umbral_mf_in), .umbral_vc_in(umbral_vc_in), .umbral_d_in(umbral_d_in),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_write(fifo_write), .fifo_read(fifo_read), .err_clr(err_clr),
        .umbral_mf(umbral_mf), .umbral_vc(umbral_vc), .umbral_d(umbral_d),
        .init_out(init_out), .idle_out(idle_out), .active_out(active_out),
        .error_out(error_out), .state(state), .active_chan(active_chan),
        .err_chan(err_chan), .err_count(err_count)
    );

    flow_ctrl_fsm #(.NCH(4), .UW(4), .ECW(2)) dut_sat (
        .clk(clk), .reset(reset), .init_req(init_req),
        .umbral_mf_in(umbral_mf_in), .umbral_vc_in(umbral_vc_in), .umbral_d_in(umbral_d_in),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_write(fifo_write), .fifo_read(fifo_read), .err_clr(err_clr),
        .umbral_mf(umbral_mf_s), .umbral_vc(umbral_vc_s), .umbral_d(umbral_d_s),
        .init_out(init_out_s), .idle_out(idle_out_s), .active_out(active_out_s),
        .error_out(error_out_s), .state(state_s), .active_chan(active_chan_s),
        .err_chan(err_chan_s), .err_count(err_count_s)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ------------------------------------------------------------------
    // Behavioural model: 0=RESET 1=INIT 2=IDLE 3=ACTIVE 4=ERROR
    // ------------------------------------------------------------------
    int         m_state   = 0;
    logic [3:0] m_mf      = 4'h0;
    logic [3:0] m_vc      = 4'h0;
    logic [3:0] m_d       = 4'h0;
    logic [3:0] m_err     = 4'h0;
    int         m_entries = 0;

    function automatic logic [3:0] ill_of(input logic [3:0] f, input logic [3:0] e,
                                          input logic [3:0] w, input logic [3:0] r);
        logic [3:0] v;
        v = 4'h0;
        for (int c = 0; c < 4; c++) begin
            if ((f[c] && e[c]) || (f[c] && w[c] && !r[c]) || (e[c] && r[c]))
                v[c] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [3:0] exp_active();
        if (m_state == 3)
            return ~fifo_empty & ~ill_of(fifo_full, fifo_empty, fifo_write, fifo_read);
        return 4'h0;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_step();
        logic [3:0] ill;
        bit         mon;
        int         nxt;
        if (!reset) begin
            m_state = 0; m_mf = 0; m_vc = 0; m_d = 0; m_err = 0; m_entries = 0;
            return;
        end
        ill = ill_of(fifo_full, fifo_empty, fifo_write, fifo_read);
        mon = (m_state >= 2) && (m_state <= 4);
        nxt = m_state;
        case (m_state)
            0: nxt = 1;
            1: begin
                if (init_req) begin
                    m_mf = umbral_mf_in; m_vc = umbral_vc_in; m_d = umbral_d_in;
                end else if ((m_mf != 0) || (m_vc != 0) || (m_d != 0)) begin
                    nxt = 2;
                end
            end
            2: begin
                if (ill != 0)               nxt = 4;
                else if (init_req)          nxt = 1;
                else if (fifo_empty != 4'hF) nxt = 3;
            end
            3: begin
                if (ill != 0)                nxt = 4;
                else if (fifo_empty == 4'hF) nxt = 2;
            end
            4: if (err_clr && ill == 0) nxt = 1;
            default: nxt = 0;
        endcase
        if (mon) begin
            if (m_state == 4 && nxt == 1) m_err = 4'h0;
            else                          m_err = m_err | ill;
        end
        if (nxt == 4 && m_state != 4) m_entries++;
        m_state = nxt;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        init_req = 1'b0; err_clr = 1'b0;
        umbral_mf_in = 4'h0; umbral_vc_in = 4'h0; umbral_d_in = 4'h0;
        fifo_full = 4'h0; fifo_empty = 4'hF; fifo_write = 4'h0; fifo_read = 4'h0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        tick();
        tick();
        n_checks++;
        if (state !== 3'd0) begin
            n_fail++; $display("FAIL reset_state: got %0d want 0", state);
        end
        n_checks++;
        if ({init_out, idle_out, active_out, error_out, active_chan} !== 8'h00) begin
            n_fail++; $display("FAIL reset_decode: got %b want 0",
                               {init_out, idle_out, active_out, error_out, active_chan});
        end
        n_checks++;
        if ({umbral_mf, umbral_vc, umbral_d, err_chan, err_count} !== 24'h0) begin
            n_fail++; $display("FAIL reset_regs: got %h want 0",
                               {umbral_mf, umbral_vc, umbral_d, err_chan, err_count});
        end
        // Release with a configuration request carrying MF=5.
        reset = 1'b1; init_req = 1'b1; umbral_mf_in = 4'h5;
        tick();
        n_checks++;
        if (state !== 3'd1 || init_out !== 1'b1 || umbral_mf !== 4'h0) begin
            n_fail++; $display("FAIL reset_to_init: got st=%0d init=%b mf=%h want 1/1/0",
                               state, init_out, umbral_mf);
        end
        tick();
        n_checks++;
        if (state !== 3'd1 || umbral_mf !== 4'h5) begin
            n_fail++; $display("FAIL init_capture: got st=%0d mf=%h want 1/5", state, umbral_mf);
        end
        init_req = 1'b0; umbral_mf_in = 4'h0;
        tick();
        n_checks++;
        if (state !== 3'd2 || idle_out !== 1'b1 || umbral_mf !== 4'h5 ||
            umbral_vc !== 4'h0 || umbral_d !== 4'h0) begin
            n_fail++; $display("FAIL init_to_idle: got st=%0d idle=%b mf=%h vc=%h d=%h want 2/1/5/0/0",
                               state, idle_out, umbral_mf, umbral_vc, umbral_d);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_init_zero();
        reset = 1'b0; idle_inputs();
        tick();
        reset = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (state !== 3'd1 || init_out !== 1'b1) begin
                n_fail++; $display("FAIL init_zero_hold[%0d]: got st=%0d init=%b want 1/1",
                                   i, state, init_out);
            end
        end
        init_req = 1'b1; umbral_mf_in = 4'h5; umbral_vc_in = 4'h3; umbral_d_in = 4'h9;
        tick();
        init_req = 1'b0; umbral_mf_in = 4'h0; umbral_vc_in = 4'h0; umbral_d_in = 4'h0;
        tick();
        n_checks++;
        if (state !== 3'd2 || {umbral_mf, umbral_vc, umbral_d} !== 12'h539) begin
            n_fail++; $display("FAIL init_load_exit: got st=%0d thr=%h want 2/539",
                               state, {umbral_mf, umbral_vc, umbral_d});
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_activity();
        fifo_empty = 4'b1011;
        tick();
        n_checks++;
        if (state !== 3'd3 || active_out !== 1'b1 || active_chan !== 4'b0100) begin
            n_fail++; $display("FAIL idle_to_active: got st=%0d act=%b chan=%b want 3/1/0100",
                               state, active_out, active_chan);
        end
        // A configuration request is ignored while transferring.
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        n_checks++;
        if (state !== 3'd3) begin
            n_fail++; $display("FAIL active_ignores_init: got %0d want 3", state);
        end
        fifo_empty = 4'hF;
        tick();
        n_checks++;
        if (state !== 3'd2 || active_chan !== 4'h0 || idle_out !== 1'b1) begin
            n_fail++; $display("FAIL active_to_idle: got st=%0d chan=%b want 2/0000", state, active_chan);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_error();
        fifo_empty = 4'b1011;
        tick();
        fifo_full = 4'b0100; fifo_write = 4'b0100; fifo_read = 4'h0;
        tick();
        n_checks++;
        if (state !== 3'd4 || error_out !== 1'b1 || err_chan !== 4'b0100 || err_count !== 8'd1) begin
            n_fail++; $display("FAIL overflow_error: got st=%0d chan=%b cnt=%0d want 4/0100/1",
                               state, err_chan, err_count);
        end
        err_clr = 1'b1;
        tick();
        n_checks++;
        if (state !== 3'd4 || err_chan !== 4'b0100 || err_count !== 8'd1) begin
            n_fail++; $display("FAIL clr_blocked: got st=%0d chan=%b cnt=%0d want 4/0100/1",
                               state, err_chan, err_count);
        end
        fifo_full = 4'h0; fifo_write = 4'h0;
        tick();
        err_clr = 1'b0;
        n_checks++;
        if (state !== 3'd1 || err_chan !== 4'h0 || err_count !== 8'd1 || umbral_mf !== 4'h5) begin
            n_fail++; $display("FAIL clr_accepted: got st=%0d chan=%b cnt=%0d mf=%h want 1/0000/1/5",
                               state, err_chan, err_count, umbral_mf);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_saturate();
        fifo_empty = 4'hF;
        for (int k = 1; k <= 5; k++) begin
            tick();                         // INIT -> IDLE
            fifo_full = 4'b0001;            // full & empty on channel 0
            tick();                         // IDLE -> ERROR
            n_checks++;
            if (state !== 3'd4 || err_count !== 8'(1 + k) ||
                int'(err_count_s) != sat(1 + k, 3)) begin
                n_fail++; $display("FAIL saturate[%0d]: got st=%0d cnt=%0d cnt2=%0d want 4/%0d/%0d",
                                   k, state, err_count, err_count_s, 1 + k, sat(1 + k, 3));
            end
            fifo_full = 4'h0; err_clr = 1'b1;
            tick();                         // ERROR -> INIT
            err_clr = 1'b0;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        tick();                             // INIT -> IDLE
        fifo_empty = 4'b0111;
        tick();                             // IDLE -> ACTIVE
        n_checks++;
        if (state !== 3'd3 || active_chan !== 4'b1000) begin
            n_fail++; $display("FAIL pre_reset_active: got st=%0d chan=%b want 3/1000", state, active_chan);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (state !== 3'd0 || {init_out, idle_out, active_out, error_out} !== 4'h0 ||
            active_chan !== 4'h0 || err_chan !== 4'h0 || err_count !== 8'h0 ||
            err_count_s !== 2'h0 || {umbral_mf, umbral_vc, umbral_d} !== 12'h0) begin
            n_fail++; $display("FAIL mid_reset: got st=%0d cnt=%0d cnt2=%0d thr=%h want all 0",
                               state, err_count, err_count_s, {umbral_mf, umbral_vc, umbral_d});
        end
        reset = 1'b1; fifo_empty = 4'hF;
        tick();
        n_checks++;
        if (state !== 3'd1 || init_out !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset_init: got st=%0d want 1", state);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_random();
        reset = 1'b0; idle_inputs();
        tick();
        for (int i = 0; i < 800; i++) begin
            reset        = ($urandom_range(0, 63) != 0);
            init_req     = ($urandom_range(0, 7) == 0);
            err_clr      = ($urandom_range(0, 3) == 0);
            umbral_mf_in = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            umbral_vc_in = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            umbral_d_in  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            fifo_empty   = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            fifo_full    = 4'($urandom) & ~fifo_empty;
            fifo_read    = 4'($urandom) & ~fifo_empty;
            fifo_write   = 4'($urandom) & ~fifo_full;
            if ($urandom_range(0, 11) == 0) begin
                fifo_full  = 4'($urandom);
                fifo_write = 4'($urandom);
                fifo_read  = 4'($urandom);
            end
            tick();
            n_checks++;
            if (state !== 3'(m_state) || state_s !== 3'(m_state)) begin
                n_fail++; $display("FAIL rnd_state[%0d]: got %0d/%0d want %0d", i, state, state_s, m_state);
            end
            n_checks++;
            if ({init_out, idle_out, active_out, error_out} !==
                {m_state == 1, m_state == 2, m_state == 3, m_state == 4}) begin
                n_fail++; $display("FAIL rnd_decode[%0d]: got %b want state %0d", i,
                                   {init_out, idle_out, active_out, error_out}, m_state);
            end
            n_checks++;
            if (active_chan !== exp_active()) begin
                n_fail++; $display("FAIL rnd_active_chan[%0d]: got %b want %b", i, active_chan, exp_active());
            end
            n_checks++;
            if (err_chan !== m_err) begin
                n_fail++; $display("FAIL rnd_err_chan[%0d]: got %b want %b", i, err_chan, m_err);
            end
            n_checks++;
            if (int'(err_count) != sat(m_entries, 255) || int'(err_count_s) != sat(m_entries, 3)) begin
                n_fail++; $display("FAIL rnd_err_count[%0d]: got %0d/%0d want %0d/%0d", i,
                                   err_count, err_count_s, sat(m_entries, 255), sat(m_entries, 3));
            end
            n_checks++;
            if ({umbral_mf, umbral_vc, umbral_d} !== {m_mf, m_vc, m_d}) begin
                n_fail++; $display("FAIL rnd_thresholds[%0d]: got %h want %h", i,
                                   {umbral_mf, umbral_vc, umbral_d}, {m_mf, m_vc, m_d});
            end
        end
    endtask

    initial begin
        test_reset();
        test_init_zero();
        test_activity();
        test_error();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
